// File: rtl/clk_div_meter.sv
// clk_div_meter
//   Measures the period and high time of a divided clock (clk_mon) in clk_in
//   cycles, checks the period against EXP_DIV +/- TOL, asserts locked after
//   LOCK_CNT consecutive good periods, and pulses err_period on a bad period
//   or on a timeout (no rising edge for 2^CNT_W-2 cycles).
//
//   Optional: define CLK_DIV_METER_DUTY_CHK_EN to also check the duty cycle
//   (floor(P/2) <= high_time <= ceil(P/2)+TOL); otherwise err_duty is 0.
//
// Ports
//   clk_in      reference clock (posedge)
//   rst         asynchronous active-high reset
//   enable      measurement enable; low forces IDLE
//   clk_mon     monitored clock, asynchronous to clk_in
//   clr_err     clears err_sticky
//   period      last measured rising-to-rising period
//   high_time   high cycles counted within that period
//   meas_valid  one-cycle pulse when period/high_time update
//   locked      frequency lock indicator
//   err_period  one-cycle pulse on bad period or timeout
//   err_duty    one-cycle pulse on duty error
//   err_sticky  sticky OR of all error pulses
module clk_div_meter #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned EXP_DIV  = 7,
  parameter int unsigned TOL      = 0,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             enable,
  input  logic             clk_mon,
  input  logic             clr_err,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             err_period,
  output logic             err_duty,
  output logic             err_sticky
);

  typedef enum logic [1:0] {IDLE, WAIT_FIRST, MEASURE} state_t;

  localparam logic [CNT_W-1:0] TMO     = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W+1:0] EXP_X   = (CNT_W+2)'(EXP_DIV);
  localparam logic [CNT_W+1:0] TOL_X   = (CNT_W+2)'(TOL);
  localparam logic [3:0]       LOCK_X  = 4'(LOCK_CNT);

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] high_acc_q, high_acc_d;
  logic [3:0]       good_cnt_q, good_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             meas_valid_q, meas_valid_d;
  logic             locked_q, locked_d;
  logic             err_period_q, err_period_d;
  logic             err_duty_q, err_duty_d;
  logic             err_sticky_q, err_sticky_d;

  logic             rise;
  logic [CNT_W+1:0] meas_p;
  logic             period_ok;
  logic             duty_ok;

  assign rise   = s2_q & ~s3_q;
  // Widened so the +1 and the tolerance window never wrap.
  assign meas_p = {2'b00, run_cnt_q} + (CNT_W+2)'(1);
  assign period_ok = (meas_p + TOL_X >= EXP_X) && (meas_p <= EXP_X + TOL_X);

`ifdef CLK_DIV_METER_DUTY_CHK_EN
  logic [CNT_W+1:0] ht_x;
  assign ht_x    = {2'b00, high_acc_q};
  assign duty_ok = (ht_x >= (meas_p >> 1)) &&
                   (ht_x <= ((meas_p + (CNT_W+2)'(1)) >> 1) + TOL_X);
`else
  assign duty_ok = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    run_cnt_d    = run_cnt_q;
    high_acc_d   = high_acc_q;
    good_cnt_d   = good_cnt_q;
    period_d     = period_q;
    high_time_d  = high_time_q;
    meas_valid_d = 1'b0;
    err_period_d = 1'b0;
    err_duty_d   = 1'b0;
    locked_d     = locked_q;

    if (!enable) begin
      state_d    = IDLE;
      run_cnt_d  = '0;
      high_acc_d = '0;
      good_cnt_d = '0;
      locked_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT_FIRST;
        WAIT_FIRST: begin
          if (rise) begin
            run_cnt_d  = '0;
            high_acc_d = CNT_W'(1);
            state_d    = MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_d     = meas_p[CNT_W-1:0];
            high_time_d  = high_acc_q;
            meas_valid_d = 1'b1;
            run_cnt_d    = '0;
            high_acc_d   = CNT_W'(1);
            if (period_ok && duty_ok) begin
              good_cnt_d = (good_cnt_q >= LOCK_X) ? LOCK_X : good_cnt_q + 4'd1;
              if (good_cnt_d == LOCK_X) locked_d = 1'b1;
            end else begin
              good_cnt_d   = '0;
              locked_d     = 1'b0;
              err_period_d = ~period_ok;
              err_duty_d   = ~duty_ok;
            end
          end else if (run_cnt_q == TMO) begin
            err_period_d = 1'b1;
            locked_d     = 1'b0;
            good_cnt_d   = '0;
            run_cnt_d    = '0;
            high_acc_d   = '0;
            state_d      = WAIT_FIRST;
          end else begin
            run_cnt_d  = run_cnt_q + CNT_W'(1);
            high_acc_d = high_acc_q + CNT_W'(s2_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Set has priority over clear.
    if (err_period_d || err_duty_d) err_sticky_d = 1'b1;
    else if (clr_err)               err_sticky_d = 1'b0;
    else                            err_sticky_d = err_sticky_q;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      run_cnt_q    <= '0;
      high_acc_q   <= '0;
      good_cnt_q   <= '0;
      period_q     <= '0;
      high_time_q  <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      err_period_q <= 1'b0;
      err_duty_q   <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_q         <= clk_mon;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      run_cnt_q    <= run_cnt_d;
      high_acc_q   <= high_acc_d;
      good_cnt_q   <= good_cnt_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
      err_period_q <= err_period_d;
      err_duty_q   <= err_duty_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_time_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign err_period = err_period_q;
  assign err_duty   = err_duty_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_clk_div_meter.sv
module tb_clk_div_meter;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       clk_mon = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] period, high_time;
  logic       meas_valid, locked, err_period, err_duty, err_sticky;

  clk_div_meter #(.CNT_W(8), .EXP_DIV(7), .TOL(0), .LOCK_CNT(4)) dut (
    .clk_in(clk_in), .rst(rst), .enable(enable), .clk_mon(clk_mon),
    .clr_err(clr_err), .period(period), .high_time(high_time),
    .meas_valid(meas_valid), .locked(locked), .err_period(err_period),
    .err_duty(err_duty), .err_sticky(err_sticky)
  );

  always #5 clk_in = ~clk_in;

  // Event monitor, sampled on the falling edge.
  int unsigned n_meas = 0, n_errp = 0, n_errp_meas = 0, n_errd = 0;
  int unsigned last_period = 0, last_high = 0;
  always @(negedge clk_in) begin
    if (meas_valid) begin
      n_meas++;
      last_period = period;
      last_high   = high_time;
    end
    if (err_period) n_errp++;
    if (err_period && meas_valid) n_errp_meas++;
    if (err_duty) n_errd++;
  end

  int unsigned n_tests = 0, n_fail = 0;

  task automatic check_eq(input string tag, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc(input logic v);
    clk_mon = v;
    @(posedge clk_in);
    #1;
  endtask

  task automatic gen(input int unsigned hi, input int unsigned lo, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      for (int unsigned i = 0; i < hi; i++) cyc(1'b1);
      for (int unsigned i = 0; i < lo; i++) cyc(1'b0);
    end
  endtask

  int unsigned m0, e0, d0, waited;

  initial begin
    // Reset state
    repeat (3) @(posedge clk_in);
    #1;
    check_eq("rst_period", period, 0);
    check_eq("rst_high", high_time, 0);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_sticky", err_sticky, 0);
    rst = 1'b0;
    enable = 1'b1;
    cyc(1'b0);

    // 1: ideal /7 stream
    m0 = n_meas; e0 = n_errp;
    gen(4, 3, 4);
    check_eq("t1_meas3", n_meas - m0, 3);
    check_eq("t1_not_locked", locked, 0);
    gen(4, 3, 1);
    check_eq("t1_meas4", n_meas - m0, 4);
    check_eq("t1_period", last_period, 7);
    check_eq("t1_high", last_high, 4);
    check_eq("t1_locked", locked, 1);
    check_eq("t1_no_err", n_errp - e0, 0);
    check_eq("t1_sticky", err_sticky, 0);

    // 2: one period of 9
    e0 = n_errp; m0 = n_errp_meas;
    gen(4, 5, 1);
    gen(4, 3, 1);
    check_eq("t2_period", last_period, 9);
    check_eq("t2_errp", n_errp - e0, 1);
    check_eq("t2_errp_with_meas", n_errp_meas - m0, 1);
    check_eq("t2_unlocked", locked, 0);
    check_eq("t2_sticky", err_sticky, 1);
    gen(4, 3, 3);
    check_eq("t2_not_yet_locked", locked, 0);
    gen(4, 3, 1);
    check_eq("t2_relocked", locked, 1);
    check_eq("t2_sticky_hold", err_sticky, 1);
    clr_err = 1'b1;
    cyc(1'b1);
    clr_err = 1'b0;
    cyc(1'b1); cyc(1'b1); cyc(1'b1);
    cyc(1'b0); cyc(1'b0); cyc(1'b0);
    check_eq("t2_sticky_clr", err_sticky, 0);
    check_eq("t2_still_locked", locked, 1);

    // 3: clk_mon stuck low -> timeout
    e0 = n_errp; m0 = n_meas; waited = 0;
    clk_mon = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (n_errp != e0) break;
      @(posedge clk_in);
      #1;
      waited++;
    end
    check_eq("t3_timeout_err", n_errp - e0, 1);
    check_eq("t3_timeout_late", (waited >= 200) ? 1 : 0, 1);
    check_eq("t3_no_meas", n_meas - m0, 0);
    check_eq("t3_unlocked", locked, 0);
    check_eq("t3_sticky", err_sticky, 1);
    m0 = n_meas;
    gen(4, 3, 5);
    check_eq("t3_meas_after_resume", n_meas - m0, 4);
    check_eq("t3_relocked", locked, 1);

    // 4: enable dropped mid-period
    m0 = n_meas; e0 = n_errp;
    cyc(1'b1); cyc(1'b1);
    enable = 1'b0;
    repeat (6) cyc(1'b0);
    check_eq("t4_unlocked", locked, 0);
    check_eq("t4_no_meas", n_meas - m0, 0);
    check_eq("t4_no_err", n_errp - e0, 0);
    enable = 1'b1;
    gen(4, 3, 1);
    check_eq("t4_first_rise_silent", n_meas - m0, 0);
    gen(4, 3, 1);
    check_eq("t4_second_rise_meas", n_meas - m0, 1);
    check_eq("t4_period", last_period, 7);
    gen(4, 3, 3);
    check_eq("t4_relocked", locked, 1);

    // 5: period 7 with one high cycle
    d0 = n_errd; e0 = n_errp;
    gen(1, 6, 1);
    gen(4, 3, 1);
    check_eq("t5_period", last_period, 7);
    check_eq("t5_high", last_high, 1);
    check_eq("t5_no_errp", n_errp - e0, 0);
`ifdef CLK_DIV_METER_DUTY_CHK_EN
    check_eq("t5_errd", n_errd - d0, 1);
    check_eq("t5_unlocked", locked, 0);
    check_eq("t5_sticky", err_sticky, 1);
`else
    check_eq("t5_errd", n_errd - d0, 0);
    check_eq("t5_locked", locked, 1);
`endif

    // 6: async reset mid-measure
    gen(4, 3, 5);
    check_eq("t6_pre_locked", locked, 1);
    cyc(1'b1); cyc(1'b1);
    rst = 1'b1;
    clk_mon = 1'b0;
    #2;
    check_eq("t6_locked", locked, 0);
    check_eq("t6_period", period, 0);
    check_eq("t6_high", high_time, 0);
    check_eq("t6_sticky", err_sticky, 0);
    check_eq("t6_meas_valid", meas_valid, 0);
    @(posedge clk_in);
    #3;
    rst = 1'b0;
    cyc(1'b0); cyc(1'b0);
    m0 = n_meas;
    gen(4, 3, 5);
    check_eq("t6_meas", n_meas - m0, 4);
    check_eq("t6_relock_period", last_period, 7);
    check_eq("t6_relocked", locked, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
